// File: rtl/uctrl_prefetch_fifo.sv
// uctrl_prefetch_fifo
//   Instruction prefetch buffer for the microcontroller decoder. A small fetch
//   FSM reads code bytes from the ROM one at a time (one request outstanding)
//   and queues {pc, byte} pairs in a circular buffer that the decoder drains.
//   A flush (jump/call/ret/interrupt) empties the buffer and redirects fetch.
//
// Parameters
//   DEPTH    : number of buffer entries (power of 2, 2..16)
//   RESET_PC : first fetch address after reset
//
// Ports
//   CK        in   clock, all state updates on the rising edge
//   R         in   synchronous active-high reset
//   rom_req   out  code-ROM read request (held until the ack cycle)
//   rom_addr  out  code-ROM byte address (held until the ack cycle)
//   rom_ack   in   ROM read complete, rom_data valid this cycle
//   rom_data  in   ROM read byte
//   ib_valid  out  head entry available to the decoder
//   ib_data   out  head byte (0 when empty)
//   ib_pc     out  address of head byte (0 when empty)
//   ib_pop    in   decoder consumes the head this cycle
//   flush     in   redirect request
//   flush_pc  in   redirect target address
//
// Build option
//   UCTRL_PREFETCH_BYPASS_EN : when defined, an ack arriving while the buffer
//   is empty is presented on ib_* in the same cycle; a same-cycle ib_pop
//   consumes it without writing the buffer. When undefined, ib_* are driven
//   from registered state only.
//
// Fetch FSM
//   state | meaning
//   IDLE  | no request outstanding; issue when there is room and no flush
//   FETCH | request outstanding; ack data is pushed into the buffer
//   DROP  | request outstanding but a flush arrived; ack data is discarded

module uctrl_prefetch_fifo #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CK,
  input  logic        R,
  output logic        rom_req,
  output logic [15:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic        ib_valid,
  output logic [7:0]  ib_data,
  output logic [15:0] ib_pc,
  input  logic        ib_pop,
  input  logic        flush,
  input  logic [15:0] flush_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetchState_t;

  fetchState_t state;
  fetchState_t stateNext;

  logic [15:0]      memPc   [DEPTH];
  logic [7:0]       memData [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic [15:0]      fetchPc;   // next address to request
  logic [15:0]      reqAddr;   // address of the outstanding request

  logic fifoEmpty;
  logic ackFetch;
  logic popFifo;
  logic pushFifo;

  assign fifoEmpty = (count == '0);
  // A flush in the ack cycle turns the ack into a discard.
  assign ackFetch  = (state == FETCH) && rom_ack && !flush;

  assign rom_req  = (state != IDLE);
  assign rom_addr = (state == IDLE) ? fetchPc : reqAddr;

  always_comb begin : ibOutputs
    ib_valid = !fifoEmpty;
    ib_data  = fifoEmpty ? 8'h00 : memData[headPtr];
    ib_pc    = fifoEmpty ? 16'h0000 : memPc[headPtr];
    popFifo  = ib_pop && !fifoEmpty && !flush;
    pushFifo = ackFetch;
`ifdef UCTRL_PREFETCH_BYPASS_EN
    if (fifoEmpty && ackFetch) begin
      ib_valid = 1'b1;
      ib_data  = rom_data;
      ib_pc    = reqAddr;
      // Consumed straight off the ROM bus: nothing to store.
      pushFifo = !ib_pop;
    end
`endif
  end

  always_comb begin : nextState
    stateNext = state;
    case (state)
      IDLE: begin
        // Room exists if the buffer is not full or the head leaves this cycle.
        if (!flush && ((count < CNT_W'(DEPTH)) || popFifo)) begin
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          stateNext = IDLE;
        end else if (flush) begin
          stateNext = DROP;
        end
      end
      DROP: begin
        if (rom_ack) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin : ctrlRegs
    if (R) begin
      state   <= IDLE;
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      fetchPc <= RESET_PC;
      reqAddr <= RESET_PC;
    end else begin
      state <= stateNext;
      if ((state == IDLE) && (stateNext == FETCH)) begin
        reqAddr <= fetchPc;
      end
      if (flush) begin
        headPtr <= '0;
        tailPtr <= '0;
        count   <= '0;
        fetchPc <= flush_pc;
      end else begin
        if (ackFetch) begin
          fetchPc <= reqAddr + 16'd1;
        end
        if (pushFifo) begin
          tailPtr <= tailPtr + PTR_W'(1);
        end
        if (popFifo) begin
          headPtr <= headPtr + PTR_W'(1);
        end
        case ({pushFifo, popFifo})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CK) begin : bufferWrite
    if (!R && pushFifo) begin
      memPc[tailPtr]   <= reqAddr;
      memData[tailPtr] <= rom_data;
    end
  end

endmodule
